// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared Y86-64 SEQ definitions: word width, icodes, stage state
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int WORD_W = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } stage_state_e;

    function automatic logic is_mem_icode(input logic [3:0] icode);
        logic r;
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        logic r;
        case (icode)
            IRMMOVQ, ICALL, IPUSHQ: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // ret and popq address the stack through valA; everything else uses valE
    function automatic logic uses_vala_addr(input logic [3:0] icode);
        return (icode == IRET) || (icode == IPOPQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_timer
// Description : Counts memory-request wait cycles and flags the timeout cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int            CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // expired is true during the TIMEOUT-th request cycle
    assign expired = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count_en && !expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Y86-64 SEQ memory stage with req/ack data-memory handshake.
//               Optional MEM_STAGE_ALIGN_CHECK_EN rejects misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [WORD_W-1:0] valE,
    input  logic [WORD_W-1:0] valA,
    input  logic [WORD_W-1:0] valP,
    output logic [WORD_W-1:0] valM,
    output logic              done,
    output logic              dmem_error,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [1:0] c_IDLE = ST_IDLE;
    localparam logic [1:0] c_REQ  = ST_REQ;
    localparam logic [1:0] c_DONE = ST_DONE;

    localparam logic [WORD_W-1:0] c_MAX_ADDR = WORD_W'(MEM_BYTES - 8);

    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_valm;
    logic              r_done;
    logic              r_err;
    logic              r_req;
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;

    logic              w_is_mem;
    logic              w_we;
    logic [WORD_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic              w_bad_addr;
    logic              w_accept;
    logic              w_in_req;
    logic              w_expired;

    always_comb begin
        w_is_mem   = is_mem_icode(icode);
        w_we       = is_mem_write(icode);
        w_addr     = uses_vala_addr(icode) ? valA : valE;
        w_wdata    = '0;
        if (icode == ICALL) begin
            w_wdata = valP;
        end else if (w_we) begin
            w_wdata = valA;
        end
        // Plain compare against MEM_BYTES-8 cannot wrap, so addresses near 2^64 fail too
        w_bad_addr = (w_addr > c_MAX_ADDR);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        w_bad_addr = w_bad_addr | (w_addr[2:0] != 3'b000);
`endif
        w_accept   = start && (r_state == c_IDLE);
        w_in_req   = (r_state == c_REQ);
    end

    mem_stage_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_accept),
        .count_en (w_in_req && !mem_ack),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_valm  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (w_is_mem && w_bad_addr) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end else if (w_is_mem) begin
                            r_req   <= 1'b1;
                            r_we    <= w_we;
                            r_addr  <= w_addr;
                            r_wdata <= w_wdata;
                            r_state <= c_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_REQ: begin
                    if (mem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_valm <= mem_rdata;
                        end
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end else if (w_expired) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign valM       = r_valm;
    assign done       = r_done;
    assign dmem_error = r_err;
    assign busy       = (r_state != c_IDLE);
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        done;
    logic        dmem_error;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int n_vec;
    int n_err;
    int req_cycles;

    mem_stage #(
        .MEM_BYTES (8192),
        .TIMEOUT   (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .valM       (valM),
        .done       (done),
        .dmem_error (dmem_error),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p);
        start = 1'b1;
        icode = ic;
        valE  = e;
        valA  = a;
        valP  = p;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        icode     = 4'h0;
        valE      = '0;
        valA      = '0;
        valP      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_err", {63'd0, dmem_error}, 64'd0);
        chk("rst_valm", valM, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        rst_n = 1'b1;
        tick();

        // rmmovq, ack on first REQ cycle
        issue(4'h4, 64'h100, 64'hDEADBEEF, 64'h0);
        chk("rm_req", {63'd0, mem_req}, 64'd1);
        chk("rm_we", {63'd0, mem_we}, 64'd1);
        chk("rm_addr", mem_addr, 64'h100);
        chk("rm_wdata", mem_wdata, 64'hDEADBEEF);
        chk("rm_done_early", {63'd0, done}, 64'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rm_done", {63'd0, done}, 64'd1);
        chk("rm_err", {63'd0, dmem_error}, 64'd0);
        chk("rm_req_drop", {63'd0, mem_req}, 64'd0);
        tick();
        chk("rm_done_pulse", {63'd0, done}, 64'd0);
        chk("rm_idle", {63'd0, busy}, 64'd0);

        // mrmovq with three wait cycles; a start during REQ must be ignored
        issue(4'h5, 64'h40, 64'h0, 64'h0);
        start = 1'b1;
        valE  = 64'h80;
        for (int i = 0; i < 3; i++) begin
            chk("mr_req_hold", {63'd0, mem_req}, 64'd1);
            chk("mr_addr_hold", mem_addr, 64'h40);
            chk("mr_we", {63'd0, mem_we}, 64'd0);
            chk("mr_wdata", mem_wdata, 64'd0);
            chk("mr_no_done", {63'd0, done}, 64'd0);
            tick();
            start = 1'b0;
        end
        mem_ack   = 1'b1;
        mem_rdata = 64'h1234;
        chk("mr_req_at_ack", {63'd0, mem_req}, 64'd1);
        tick();
        mem_ack = 1'b0;
        chk("mr_done", {63'd0, done}, 64'd1);
        chk("mr_valm", valM, 64'h1234);
        tick();

        // popq addresses via valA
        issue(4'hB, 64'h208, 64'h200, 64'h0);
        chk("pop_addr", mem_addr, 64'h200);
        chk("pop_we", {63'd0, mem_we}, 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 64'hAA55;
        tick();
        mem_ack = 1'b0;
        chk("pop_valm", valM, 64'hAA55);
        tick();

        // call writes valP
        issue(4'h8, 64'h300, 64'h999, 64'h3C);
        chk("call_addr", mem_addr, 64'h300);
        chk("call_we", {63'd0, mem_we}, 64'd1);
        chk("call_wdata", mem_wdata, 64'h3C);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("call_done", {63'd0, done}, 64'd1);
        tick();

        // out of range: 0x1FFC + 8 > 8192
        issue(4'h4, 64'h1FFC, 64'h1, 64'h0);
        chk("oor_req", {63'd0, mem_req}, 64'd0);
        chk("oor_done", {63'd0, done}, 64'd1);
        chk("oor_err", {63'd0, dmem_error}, 64'd1);
        tick();
        chk("oor_err_hold", {63'd0, dmem_error}, 64'd1);
        chk("oor_done_pulse", {63'd0, done}, 64'd0);

        // top in-range address; error clears on acceptance
        issue(4'h5, 64'h1FF8, 64'h0, 64'h0);
        chk("edge_req", {63'd0, mem_req}, 64'd1);
        chk("edge_err_clr", {63'd0, dmem_error}, 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h77;
        tick();
        mem_ack = 1'b0;
        chk("edge_valm", valM, 64'h77);
        tick();

        // address near 2^64 must not wrap into range
        issue(4'hA, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5, 64'h0);
        chk("wrap_req", {63'd0, mem_req}, 64'd0);
        chk("wrap_err", {63'd0, dmem_error}, 64'd1);
        tick();

        // no-access icode
        issue(4'h6, 64'h100, 64'h0, 64'h0);
        chk("opq_req", {63'd0, mem_req}, 64'd0);
        chk("opq_done", {63'd0, done}, 64'd1);
        chk("opq_err", {63'd0, dmem_error}, 64'd0);
        chk("opq_valm", valM, 64'h77);
        tick();

        // timeout: request held exactly 16 cycles
        issue(4'h5, 64'h10, 64'h0, 64'h0);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (mem_req) req_cycles++;
            tick();
        end
        chk("to_done", {63'd0, done}, 64'd1);
        chk("to_req_cycles", 64'(req_cycles), 64'd16);
        chk("to_err", {63'd0, dmem_error}, 64'd1);
        chk("to_req_drop", {63'd0, mem_req}, 64'd0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 64'hBAD;
        tick();
        mem_ack = 1'b0;
        chk("stray_busy", {63'd0, busy}, 64'd0);
        chk("stray_done", {63'd0, done}, 64'd0);
        chk("stray_valm", valM, 64'h77);

        // asynchronous reset mid-REQ
        issue(4'h4, 64'h20, 64'h5, 64'h0);
        chk("rr_req", {63'd0, mem_req}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_req0", {63'd0, mem_req}, 64'd0);
        chk("rr_addr0", mem_addr, 64'd0);
        chk("rr_wdata0", mem_wdata, 64'd0);
        chk("rr_busy0", {63'd0, busy}, 64'd0);
        chk("rr_valm0", valM, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(4'h4, 64'h28, 64'h6, 64'h0);
        chk("rr_new_req", {63'd0, mem_req}, 64'd1);
        chk("rr_new_addr", mem_addr, 64'h28);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rr_new_done", {63'd0, done}, 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
